branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_branch_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// cotm32_pkg : shared core types (XLEN, branch-unit opcode) and the branch
//              compare function used by the branch unit.
// branch_ctrl: resolves one branch/jump at a time. A request is captured in
//              IDLE, evaluated in a single EVAL cycle, and a mispredict drives
//              a redirect handshake followed by FLUSH_CYCLES cycles of flush.
//
// Ports (branch_ctrl)
//   i_clk, i_rst          clock (rising edge), async active-high reset
//   i_req_valid/o_req_ready          request handshake (ready only in IDLE)
//   i_pc, i_imm, i_rs1, i_rs2, i_op  branch operands and compare condition
//   i_is_jal, i_is_jalr              unconditional jump flags (JALR wins)
//   i_pred_taken                     direction predicted by fetch
//   o_resolved_valid/_taken          one-cycle resolution pulse + direction
//   o_mispredict, o_misalign         resolution flags, valid with the pulse
//   o_redirect_valid/i_redirect_ready, o_redirect_pc   fetch redirect
//   o_flush, o_stall                 pipeline kill / hold
//   o_branch_count, o_mispredict_count   wrapping statistics counters
// -----------------------------------------------------------------------------
package cotm32_pkg;

    localparam int XLEN = 32;

    // Encodings follow the RISC-V funct3 field; 3'b010/3'b011 are undefined.
    typedef enum logic [2:0] {
        BU_BEQ  = 3'b000,
        BU_BNE  = 3'b001,
        BU_BLT  = 3'b100,
        BU_BGE  = 3'b101,
        BU_BLTU = 3'b110,
        BU_BGEU = 3'b111
    } bu_op_t;

    // Branch unit compare; any undefined opcode resolves as not taken.
    function automatic logic bu_take(input bu_op_t op,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        case (op)
            BU_BEQ:  bu_take = (a == b);
            BU_BNE:  bu_take = (a != b);
            BU_BLT:  bu_take = ($signed(a) <  $signed(b));
            BU_BGE:  bu_take = ($signed(a) >= $signed(b));
            BU_BLTU: bu_take = (a <  b);
            BU_BGEU: bu_take = (a >= b);
            default: bu_take = 1'b0;
        endcase
    endfunction

endpackage

module branch_ctrl
    import cotm32_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  bu_op_t          i_op,
    input  logic            i_is_jal,
    input  logic            i_is_jalr,
    input  logic            i_pred_taken,
    output logic            o_resolved_valid,
    output logic            o_resolved_taken,
    output logic            o_mispredict,
    output logic            o_misalign,
    output logic            o_redirect_valid,
    input  logic            i_redirect_ready,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_flush,
    output logic            o_stall,
    output logic [31:0]     o_branch_count,
    output logic [31:0]     o_mispredict_count
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_EVAL     = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;
    localparam logic [1:0] S_FLUSH    = 2'd3;

    // The flush counter holds "cycles remaining minus one", so it needs to
    // represent FLUSH_CYCLES-1; keep at least one bit for FLUSH_CYCLES <= 1.
    localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] FLUSH_LOAD =
        (FLUSH_CYCLES > 0) ? CNT_W'(FLUSH_CYCLES - 1) : '0;

    logic [1:0]       state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    bu_op_t           op_q, op_d;
    logic             jal_q, jal_d;
    logic             jalr_q, jalr_d;
    logic             pred_q, pred_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [31:0]      branch_count_q, branch_count_d;
    logic [31:0]      mispredict_count_q, mispredict_count_d;

    // Resolution of the captured request; only meaningful in EVAL.
    logic             taken;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  next_pc;
    logic             misalign;
    logic             mispredict_raw;
    logic             need_redirect;

    always_comb begin
        jalr_sum       = rs1_q + imm_q;
        taken          = jal_q | jalr_q | bu_take(op_q, rs1_q, rs2_q);
        target         = jalr_q ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_q + imm_q);
        next_pc        = taken ? target : (pc_q + XLEN'(4));
        misalign       = taken & target[1];
        // JALR targets are never predicted, so it always redirects.
        mispredict_raw = (taken != pred_q) | jalr_q;
        need_redirect  = mispredict_raw & ~misalign;
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d            = state_q;
        pc_d               = pc_q;
        imm_d              = imm_q;
        rs1_d              = rs1_q;
        rs2_d              = rs2_q;
        op_d               = op_q;
        jal_d              = jal_q;
        jalr_d             = jalr_q;
        pred_d             = pred_q;
        redirect_pc_d      = redirect_pc_q;
        flush_cnt_d        = flush_cnt_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;

        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    pc_d    = i_pc;
                    imm_d   = i_imm;
                    rs1_d   = i_rs1;
                    rs2_d   = i_rs2;
                    op_d    = i_op;
                    jal_d   = i_is_jal;
                    jalr_d  = i_is_jalr;
                    pred_d  = i_pred_taken;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                branch_count_d = branch_count_q + 32'd1;
                if (need_redirect) begin
                    redirect_pc_d = next_pc;
                    state_d       = S_REDIRECT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REDIRECT: begin
                if (i_redirect_ready) begin
                    mispredict_count_d = mispredict_count_q + 32'd1;
                    flush_cnt_d        = FLUSH_LOAD;
                    state_d            = (FLUSH_CYCLES == 0) ? S_IDLE : S_FLUSH;
                end
            end
            default: begin // S_FLUSH
                if (flush_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q            <= S_IDLE;
            pc_q               <= '0;
            imm_q              <= '0;
            rs1_q              <= '0;
            rs2_q              <= '0;
            op_q               <= BU_BEQ;
            jal_q              <= 1'b0;
            jalr_q             <= 1'b0;
            pred_q             <= 1'b0;
            redirect_pc_q      <= '0;
            flush_cnt_q        <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            state_q            <= state_d;
            pc_q               <= pc_d;
            imm_q              <= imm_d;
            rs1_q              <= rs1_d;
            rs2_q              <= rs2_d;
            op_q               <= op_d;
            jal_q              <= jal_d;
            jalr_q             <= jalr_d;
            pred_q             <= pred_d;
            redirect_pc_q      <= redirect_pc_d;
            flush_cnt_q        <= flush_cnt_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // All outputs are decoded from the state so an asynchronous reset
    // clears them in the same instant it forces IDLE.
    always_comb begin
        o_req_ready        = (state_q == S_IDLE);
        o_stall            = (state_q != S_IDLE);
        o_resolved_valid   = (state_q == S_EVAL);
        o_resolved_taken   = (state_q == S_EVAL) & taken;
        o_misalign         = (state_q == S_EVAL) & misalign;
        o_mispredict       = (state_q == S_EVAL) & need_redirect;
        o_redirect_valid   = (state_q == S_REDIRECT);
        o_redirect_pc      = (state_q == S_REDIRECT) ? redirect_pc_q : '0;
        o_flush            = (state_q == S_REDIRECT) | (state_q == S_FLUSH);
        o_branch_count     = branch_count_q;
        o_mispredict_count = mispredict_count_q;
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for branch_ctrl: a table of single-request vectors with
// hand-computed results, then hand-written sequences for redirect
// back-pressure, misaligned jumps and reset in the middle of a flush.
// -----------------------------------------------------------------------------
module tb_branch_ctrl;
    import cotm32_pkg::*;

    localparam int FLUSH = 2;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_pc, i_imm, i_rs1, i_rs2;
    bu_op_t      i_op;
    logic        i_is_jal, i_is_jalr, i_pred_taken;
    logic        o_resolved_valid, o_resolved_taken, o_mispredict, o_misalign;
    logic        o_redirect_valid, i_redirect_ready;
    logic [31:0] o_redirect_pc;
    logic        o_flush, o_stall;
    logic [31:0] o_branch_count, o_mispredict_count;

    branch_ctrl #(.FLUSH_CYCLES(FLUSH)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_req_valid        (i_req_valid),
        .o_req_ready        (o_req_ready),
        .i_pc               (i_pc),
        .i_imm              (i_imm),
        .i_rs1              (i_rs1),
        .i_rs2              (i_rs2),
        .i_op               (i_op),
        .i_is_jal           (i_is_jal),
        .i_is_jalr          (i_is_jalr),
        .i_pred_taken       (i_pred_taken),
        .o_resolved_valid   (o_resolved_valid),
        .o_resolved_taken   (o_resolved_taken),
        .o_mispredict       (o_mispredict),
        .o_misalign         (o_misalign),
        .o_redirect_valid   (o_redirect_valid),
        .i_redirect_ready   (i_redirect_ready),
        .o_redirect_pc      (o_redirect_pc),
        .o_flush            (o_flush),
        .o_stall            (o_stall),
        .o_branch_count     (o_branch_count),
        .o_mispredict_count (o_mispredict_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bu_op_t      op;
        logic [31:0] pc, imm, rs1, rs2;
        logic        jal, jalr, pred;
        logic        taken, redirect;
        logic [31:0] rpc;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_bc  = 0;
    int exp_mc  = 0;
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bu_op_t op, input logic [31:0] pc, imm, rs1, rs2,
                                input logic jal, jalr, pred, taken, redirect,
                                input logic [31:0] rpc);
        vec_t v;
        v.op = op; v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2;
        v.jal = jal; v.jalr = jalr; v.pred = pred;
        v.taken = taken; v.redirect = redirect; v.rpc = rpc;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        i_op = v.op; i_pc = v.pc; i_imm = v.imm; i_rs1 = v.rs1; i_rs2 = v.rs2;
        i_is_jal = v.jal; i_is_jalr = v.jalr; i_pred_taken = v.pred;
        i_req_valid = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 20 && !o_req_ready; k++) @(negedge i_clk);
        check({tag, " idle_reached"}, {31'd0, o_req_ready}, 32'd1);
    endtask

    // Called at a negedge while IDLE; redirect_ready must be held high.
    task automatic run_vec(input string tag, input vec_t v);
        check({tag, " req_ready"}, {31'd0, o_req_ready}, 32'd1);
        apply(v);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        check({tag, " resolved_valid"}, {31'd0, o_resolved_valid}, 32'd1);
        check({tag, " taken"},          {31'd0, o_resolved_taken}, {31'd0, v.taken});
        check({tag, " mispredict"},     {31'd0, o_mispredict},     {31'd0, v.redirect});
        check({tag, " misalign"},       {31'd0, o_misalign},       32'd0);
        check({tag, " eval_stall"},     {31'd0, o_stall},          32'd1);
        check({tag, " eval_flush"},     {31'd0, o_flush},          32'd0);
        exp_bc++;
        if (v.redirect) begin
            @(negedge i_clk);
            check({tag, " redirect_valid"}, {31'd0, o_redirect_valid}, 32'd1);
            check({tag, " redirect_pc"},    o_redirect_pc,             v.rpc);
            check({tag, " redirect_flush"}, {31'd0, o_flush},          32'd1);
            check({tag, " pulse_gone"},     {31'd0, o_resolved_valid}, 32'd0);
            exp_mc++;
            for (int k = 0; k < FLUSH; k++) begin
                @(negedge i_clk);
                check({tag, " flush"},        {31'd0, o_flush},          32'd1);
                check({tag, " flush_no_rv"},  {31'd0, o_redirect_valid}, 32'd0);
                check({tag, " flush_stall"},  {31'd0, o_stall},          32'd1);
            end
        end
        @(negedge i_clk);
        check({tag, " back_idle"},  {31'd0, o_req_ready}, 32'd1);
        check({tag, " idle_stall"}, {31'd0, o_stall},     32'd0);
        check({tag, " idle_flush"}, {31'd0, o_flush},     32'd0);
        check({tag, " branch_cnt"}, o_branch_count,       32'(exp_bc));
        check({tag, " mispr_cnt"},  o_mispredict_count,   32'(exp_mc));
    endtask

    initial begin
        vec_t v;
        vecs[0]  = mk(BU_BEQ,  32'h100,      32'h20,       32'd5,        32'd5, 0, 0, 1, 1, 0, 32'h0);
        vecs[1]  = mk(BU_BLT,  32'h200,      32'h40,       32'hFFFFFFFF, 32'd1, 0, 0, 0, 1, 1, 32'h240);
        vecs[2]  = mk(BU_BEQ,  32'h300,      32'h0,        32'h1001,     32'd0, 0, 1, 1, 1, 1, 32'h1000);
        vecs[3]  = mk(BU_BEQ,  32'hFFFFFFFC, 32'h100,      32'd1,        32'd2, 0, 0, 1, 0, 1, 32'h0);
        vecs[4]  = mk(BU_BNE,  32'h400,      32'h10,       32'd3,        32'd3, 0, 0, 0, 0, 0, 32'h0);
        vecs[5]  = mk(BU_BGE,  32'h404,      32'h8,        32'hFFFFFFFF, 32'd1, 0, 0, 0, 0, 0, 32'h0);
        vecs[6]  = mk(BU_BGEU, 32'h500,      32'hFFFFFFF8, 32'hFFFFFFFF, 32'd1, 0, 0, 1, 1, 0, 32'h0);
        vecs[7]  = mk(bu_op_t'(3'b010), 32'h600, 32'h10,   32'd7,        32'd7, 0, 0, 0, 0, 0, 32'h0);
        vecs[8]  = mk(BU_BNE,  32'h700,      32'h10,       32'h2000,     32'd0, 1, 1, 1, 1, 1, 32'h2010);
        vecs[9]  = mk(BU_BEQ,  32'hFFFFFFF0, 32'h20,       32'd9,        32'd9, 0, 0, 0, 1, 1, 32'h10);
        vecs[10] = mk(BU_BLTU, 32'h800,      32'h40,       32'hFFFFFFFF, 32'd1, 0, 0, 0, 0, 0, 32'h0);

        i_rst = 1'b1; i_req_valid = 1'b0; i_redirect_ready = 1'b1;
        i_pc = '0; i_imm = '0; i_rs1 = '0; i_rs2 = '0; i_op = BU_BEQ;
        i_is_jal = 1'b0; i_is_jalr = 1'b0; i_pred_taken = 1'b0;

        repeat (2) @(negedge i_clk);
        check("rst req_ready",      {31'd0, o_req_ready},      32'd1);
        check("rst stall",          {31'd0, o_stall},          32'd0);
        check("rst redirect_valid", {31'd0, o_redirect_valid}, 32'd0);
        check("rst redirect_pc",    o_redirect_pc,             32'd0);
        check("rst branch_cnt",     o_branch_count,            32'd0);
        i_rst = 1'b0;

        // First vector is requested in the same cycle reset drops.
        for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // BLTU mispredict with fetch back-pressure for five cycles.
        i_redirect_ready = 1'b0;
        apply(mk(BU_BLTU, 32'h200, 32'h40, 32'hFFFFFFFF, 32'd1, 0, 0, 1, 0, 1, 32'h204));
        @(negedge i_clk);
        i_req_valid = 1'b0;
        check("bp taken",      {31'd0, o_resolved_taken}, 32'd0);
        check("bp mispredict", {31'd0, o_mispredict},     32'd1);
        exp_bc++;
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            check($sformatf("bp hold%0d valid", k), {31'd0, o_redirect_valid}, 32'd1);
            check($sformatf("bp hold%0d pc", k),    o_redirect_pc,             32'h204);
            check($sformatf("bp hold%0d stall", k), {31'd0, o_stall},          32'd1);
            check($sformatf("bp hold%0d cnt", k),   o_mispredict_count,        32'(exp_mc));
        end
        i_redirect_ready = 1'b1;
        @(negedge i_clk);
        exp_mc++;
        check("bp after_hs valid", {31'd0, o_redirect_valid}, 32'd0);
        check("bp after_hs flush", {31'd0, o_flush},          32'd1);
        check("bp mispr_cnt",      o_mispredict_count,        32'(exp_mc));
        wait_idle("bp");

        // JAL to a misaligned target: resolved taken, but no redirect.
        apply(mk(BU_BEQ, 32'h10, 32'h6, 32'd0, 32'd1, 1, 0, 0, 1, 0, 32'h0));
        @(negedge i_clk);
        i_req_valid = 1'b0;
        check("mis taken",      {31'd0, o_resolved_taken}, 32'd1);
        check("mis misalign",   {31'd0, o_misalign},       32'd1);
        check("mis mispredict", {31'd0, o_mispredict},     32'd0);
        @(negedge i_clk);
        check("mis idle",           {31'd0, o_req_ready},      32'd1);
        check("mis redirect_valid", {31'd0, o_redirect_valid}, 32'd0);
        check("mis mispr_cnt",      o_mispredict_count,        32'(exp_mc));

        // Reset asserted in the middle of FLUSH.
        v = vecs[1];
        apply(v);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        check("rf in_flush", {31'd0, o_flush}, 32'd1);
        i_rst = 1'b1;
        #1;
        check("rf req_ready",      {31'd0, o_req_ready},      32'd1);
        check("rf flush",          {31'd0, o_flush},          32'd0);
        check("rf stall",          {31'd0, o_stall},          32'd0);
        check("rf redirect_valid", {31'd0, o_redirect_valid}, 32'd0);
        check("rf redirect_pc",    o_redirect_pc,             32'd0);
        check("rf branch_cnt",     o_branch_count,            32'd0);
        check("rf mispr_cnt",      o_mispredict_count,        32'd0);
        @(negedge i_clk);
        i_rst  = 1'b0;
        exp_bc = 0;
        exp_mc = 0;
        run_vec("post_rst0", vecs[0]);
        run_vec("post_rst1", vecs[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Guard against a hung design; prints a failure and stops.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
